// File: rtl/traffic_pkg.sv
// Shared types for the intersection phase sequencer: phase and FSM
// encodings, the sequencer's registered state record, and the mapping from
// a phase to the green outputs it drives.
package traffic_pkg;

    // Phase encoding doubles as the bit index into pending[3:0] and the
    // green vector {ped, turn, down, up}.
    typedef enum logic [1:0] {
        PH_UP   = 2'd0,
        PH_DOWN = 2'd1,
        PH_TURN = 2'd2,
        PH_PED  = 2'd3
    } phase_t;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_GREEN = 2'd2
    } state_t;

    // Everything the FSM remembers apart from the timer; kept as one record
    // so a checker can bind to a single signal.
    typedef struct packed {
        state_t state;
        phase_t cur_phase;
        phase_t last_served;
    } seq_state_t;

    localparam int NUM_PHASES = 4;

    // Green vector {ped, turn, down, up} driven while a phase is active.
    // PED also lights the turn lane so the turning traffic is held by the
    // same signal the crossing checks watch.
    function automatic logic [3:0] phase_greens(input phase_t ph);
        logic [3:0] g;
        g = 4'b0000;
        case (ph)
            PH_UP:   g = 4'b0001;
            PH_DOWN: g = 4'b0010;
            PH_TURN: g = 4'b0100;
            PH_PED:  g = 4'b1100;
            default: g = 4'b0000;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/rr_phase_arbiter.sv
// Combinational round-robin pick among pending phases. The scan starts at
// the phase after last_served and wraps, so the phase just served is
// considered last.
module rr_phase_arbiter
    import traffic_pkg::*;
(
    input  logic [3:0] pending,
    input  phase_t     last_served,
    output phase_t     grant,
    output logic       valid
);

    logic [1:0] idx;

    // First set pending bit in the order last_served+1, +2, +3, +4 (mod 4).
    // valid is high whenever any bit is set; grant is only meaningful then.
    always_comb begin
        grant = PH_UP;
        valid = 1'b0;
        idx   = 2'd0;
        for (int i = 1; i <= NUM_PHASES; i++) begin
            idx = 2'(int'(last_served) + i);
            if (!valid && pending[idx]) begin
                valid = 1'b1;
                grant = phase_t'(idx);
            end
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// Intersection phase sequencer: latches demand from the pedestrian button
// and the loop sensors, grants phases round-robin, enforces a minimum green
// per phase and an all-red clearance interval between any two greens.
module phase_sequencer
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN    = 8,
    parameter int CLEAR_CYCLES = 3,
    parameter int CNT_W        = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ped_req,
    input  logic       up_req,
    input  logic       down_req,
    input  logic       turn_req,
    output logic       pedestrian_green,
    output logic       up_green,
    output logic       down_green,
    output logic       turn_green,
    output logic [3:0] pending
);

    localparam logic [CNT_W-1:0] MIN_GREEN_C = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] CLEAR_C     = CNT_W'(CLEAR_CYCLES);
    localparam logic [CNT_W-1:0] ONE_C       = CNT_W'(1);

    seq_state_t       seq_q, seq_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [3:0]       pend_q, pend_d;
    logic [3:0]       greens_q, greens_d;
    logic [3:0]       req_vec;
    logic [3:0]       served_mask;
    logic [3:0]       clr_mask;
    logic             enter_green;
    phase_t           arb_grant;
    logic             arb_valid;

    assign req_vec = {ped_req, turn_req, down_req, up_req};

    // A phase that is currently green ignores its own sensor: that demand
    // is already being served.
    assign served_mask = (seq_q.state == ST_GREEN) ? (4'b0001 << seq_q.cur_phase)
                                                   : 4'b0000;

    rr_phase_arbiter u_arb (
        .pending     (pend_q),
        .last_served (seq_q.last_served),
        .grant       (arb_grant),
        .valid       (arb_valid)
    );

    // Next-state, timer and green outputs. Arbitration looks only at the
    // latched demand, so a request is granted no earlier than the edge after
    // the one that latched it.
    always_comb begin
        seq_d       = seq_q;
        timer_d     = timer_q;
        greens_d    = greens_q;
        enter_green = 1'b0;
        clr_mask    = 4'b0000;

        case (seq_q.state)
            ST_CLEAR: begin
                greens_d = 4'b0000;
                timer_d  = timer_q - ONE_C;
                if (timer_q <= ONE_C) begin
                    if (arb_valid) begin
                        enter_green = 1'b1;
                    end else begin
                        seq_d.state = ST_IDLE;
                        timer_d     = '0;
                    end
                end
            end
            ST_IDLE: begin
                greens_d = 4'b0000;
                if (arb_valid) begin
                    enter_green = 1'b1;
                end
            end
            ST_GREEN: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - ONE_C;
                end else if (pend_q != 4'b0000) begin
                    // Minimum green met and someone else is waiting.
                    seq_d.state       = ST_CLEAR;
                    seq_d.last_served = seq_q.cur_phase;
                    timer_d           = CLEAR_C;
                    greens_d          = 4'b0000;
                end
            end
            default: begin
                seq_d.state = ST_CLEAR;
                timer_d     = CLEAR_C;
                greens_d    = 4'b0000;
            end
        endcase

        if (enter_green) begin
            seq_d.state     = ST_GREEN;
            seq_d.cur_phase = arb_grant;
            timer_d         = MIN_GREEN_C;
            greens_d        = phase_greens(arb_grant);
            clr_mask        = 4'b0001 << arb_grant;
        end
    end

    // Demand latch: new requests set bits; the winner's bit is consumed on
    // the edge that turns it green, taking precedence over a same-cycle req.
    always_comb begin
        pend_d = (pend_q | (req_vec & ~served_mask)) & ~clr_mask;
    end

    // State, timer, demand and green registers with synchronous reset into
    // a full clearance interval.
    always_ff @(posedge clock) begin
        if (reset) begin
            seq_q.state       <= ST_CLEAR;
            seq_q.cur_phase   <= PH_UP;
            seq_q.last_served <= PH_PED;
            timer_q           <= CLEAR_C;
            pend_q            <= 4'b0000;
            greens_q          <= 4'b0000;
        end else begin
            seq_q    <= seq_d;
            timer_q  <= timer_d;
            pend_q   <= pend_d;
            greens_q <= greens_d;
        end
    end

    assign up_green         = greens_q[0];
    assign down_green       = greens_q[1];
    assign turn_green       = greens_q[2];
    assign pedestrian_green = greens_q[3];
    assign pending          = pend_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer. Inputs change and outputs are
// sampled on the falling clock edge. Expected grant order is queued when
// requests are driven and popped when a green appears.
module tb_phase_sequencer;

    localparam int MIN_GREEN    = 8;
    localparam int CLEAR_CYCLES = 3;
    localparam int CNT_W        = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ped_req = 1'b0;
    logic       up_req = 1'b0;
    logic       down_req = 1'b0;
    logic       turn_req = 1'b0;
    logic       pedestrian_green;
    logic       up_green;
    logic       down_green;
    logic       turn_green;
    logic [3:0] pending;
    logic [3:0] greens;

    int         n_cmp = 0;
    int         n_err = 0;
    int         inv_viol = 0;
    logic [3:0] prev_g = 4'b0000;
    logic [3:0] exp_q[$];

    // Clock block
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    phase_sequencer #(
        .MIN_GREEN    (MIN_GREEN),
        .CLEAR_CYCLES (CLEAR_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .ped_req          (ped_req),
        .up_req           (up_req),
        .down_req         (down_req),
        .turn_req         (turn_req),
        .pedestrian_green (pedestrian_green),
        .up_green         (up_green),
        .down_green       (down_green),
        .turn_green       (turn_green),
        .pending          (pending)
    );

    assign greens = {pedestrian_green, turn_green, down_green, up_green};

    // Safety invariants on every sampled cycle
    always @(negedge clock) begin
        if (!reset) begin
            if (pedestrian_green && !turn_green) inv_viol <= inv_viol + 1;
            if (up_green && down_green) inv_viol <= inv_viol + 1;
            if ((32'(up_green) + 32'(down_green) + 32'(turn_green)) > 1) inv_viol <= inv_viol + 1;
            if (prev_g != 4'b0000 && greens != 4'b0000 && greens != prev_g) inv_viol <= inv_viol + 1;
        end
        prev_g <= reset ? 4'b0000 : greens;
    end

    // Driver tasks
    task automatic tick(input int n = 1);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        tick(2);
        reset = 1'b0;
        tick(CLEAR_CYCLES + 2);
    endtask

    task automatic wait_green(output logic [3:0] g, output int waited, output bit tmo);
        waited = 0;
        while (greens == 4'b0000 && waited < 60) begin
            waited++;
            tick();
        end
        tmo = (greens == 4'b0000);
        g   = greens;
    endtask

    task automatic measure(input logic [3:0] g, input int bound, output int len);
        len = 0;
        while (greens == g && len < bound) begin
            len++;
            tick();
        end
    endtask

    task automatic test_reset();
        int bad;
        reset = 1'b1;
        tick(2);
        n_cmp++;
        if (greens !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_greens: actual=%b required=0000", greens);
        end
        n_cmp++;
        if (pending !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_pending: actual=%b required=0000", pending);
        end
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < CLEAR_CYCLES + 20; i++) begin
            tick();
            if (greens !== 4'b0000 || pending !== 4'b0000) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL reset_idle_quiet: actual=%0d non-quiet cycles required=0", bad);
        end
    endtask

    task automatic test_single_up();
        logic [3:0] e;
        int bad;
        do_reset();
        up_req = 1'b1;
        exp_q.push_back(4'b0001);
        tick();
        up_req = 1'b0;
        n_cmp++;
        if (pending !== 4'b0001 || greens !== 4'b0000) begin
            n_err++;
            $display("FAIL up_latch: actual pending=%b greens=%b required pending=0001 greens=0000", pending, greens);
        end
        tick();
        e = exp_q.pop_front();
        n_cmp++;
        if (greens !== e || pending !== 4'b0000) begin
            n_err++;
            $display("FAIL up_grant: actual greens=%b pending=%b required greens=%b pending=0000", greens, pending, e);
        end
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (greens !== 4'b0001) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL up_rest: actual=%0d cycles off required=0", bad);
        end
    endtask

    task automatic test_min_green();
        logic [3:0] g;
        logic [3:0] e;
        int w;
        int len;
        bit t;
        do_reset();
        up_req = 1'b1;
        exp_q.push_back(4'b0001);
        tick();
        up_req = 1'b0;
        wait_green(g, w, t);
        e = exp_q.pop_front();
        n_cmp++;
        if (t || g !== e) begin
            n_err++;
            $display("FAIL mg_first: actual=%b timeout=%0d required=%b", g, t, e);
        end
        tick();
        down_req = 1'b1;
        exp_q.push_back(4'b0010);
        tick();
        down_req = 1'b0;
        measure(4'b0001, 40, len);
        n_cmp++;
        if (len + 2 != MIN_GREEN + 1) begin
            n_err++;
            $display("FAIL mg_up_len: actual=%0d required=%0d", len + 2, MIN_GREEN + 1);
        end
        wait_green(g, w, t);
        e = exp_q.pop_front();
        n_cmp++;
        if (t || g !== e || w != CLEAR_CYCLES) begin
            n_err++;
            $display("FAIL mg_second: actual=%b allred=%0d required=%b allred=%0d", g, w, e, CLEAR_CYCLES);
        end
        measure(4'b0010, 20, len);
        n_cmp++;
        if (len != 20) begin
            n_err++;
            $display("FAIL mg_down_rest: actual=%0d required=20", len);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] g;
        logic [3:0] e;
        int w;
        int len;
        int exp_len;
        bit t;
        do_reset();
        ped_req  = 1'b1;
        up_req   = 1'b1;
        down_req = 1'b1;
        turn_req = 1'b1;
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1100);
        tick();
        ped_req  = 1'b0;
        up_req   = 1'b0;
        down_req = 1'b0;
        turn_req = 1'b0;
        for (int p = 0; p < 4; p++) begin
            wait_green(g, w, t);
            e = exp_q.pop_front();
            n_cmp++;
            if (t || g !== e) begin
                n_err++;
                $display("FAIL rr_order_%0d: actual=%b timeout=%0d required=%b", p, g, t, e);
            end
            if (p > 0) begin
                n_cmp++;
                if (w != CLEAR_CYCLES) begin
                    n_err++;
                    $display("FAIL rr_allred_%0d: actual=%0d required=%0d", p, w, CLEAR_CYCLES);
                end
            end
            measure(g, 20, len);
            exp_len = (p < 3) ? MIN_GREEN + 1 : 20;
            n_cmp++;
            if (len != exp_len) begin
                n_err++;
                $display("FAIL rr_len_%0d: actual=%0d required=%0d", p, len, exp_len);
            end
        end
    endtask

    task automatic test_ped_ignore();
        logic [3:0] g;
        logic [3:0] e;
        int w;
        int len;
        bit t;
        ped_req = 1'b1;
        tick();
        ped_req = 1'b0;
        tick();
        n_cmp++;
        if (pending !== 4'b0000 || greens !== 4'b1100) begin
            n_err++;
            $display("FAIL ped_ignore: actual pending=%b greens=%b required pending=0000 greens=1100", pending, greens);
        end
        turn_req = 1'b1;
        exp_q.push_back(4'b0100);
        tick();
        turn_req = 1'b0;
        n_cmp++;
        if (pending !== 4'b0100) begin
            n_err++;
            $display("FAIL ped_turn_latch: actual=%b required=0100", pending);
        end
        measure(4'b1100, 10, len);
        n_cmp++;
        if (len != 1) begin
            n_err++;
            $display("FAIL ped_end: actual=%0d required=1", len);
        end
        wait_green(g, w, t);
        e = exp_q.pop_front();
        n_cmp++;
        if (t || g !== e || w != CLEAR_CYCLES || pedestrian_green !== 1'b0) begin
            n_err++;
            $display("FAIL ped_turn_alone: actual=%b allred=%0d required=%b allred=%0d", g, w, e, CLEAR_CYCLES);
        end
    endtask

    task automatic test_reset_mid_green();
        logic [3:0] g;
        logic [3:0] e;
        int w;
        int bad;
        bit t;
        do_reset();
        down_req = 1'b1;
        exp_q.push_back(4'b0010);
        tick();
        down_req = 1'b0;
        wait_green(g, w, t);
        e = exp_q.pop_front();
        n_cmp++;
        if (t || g !== e) begin
            n_err++;
            $display("FAIL rm_down: actual=%b required=%b", g, e);
        end
        tick();
        up_req = 1'b1;
        exp_q.push_back(4'b0001);
        tick();
        up_req = 1'b0;
        tick();
        n_cmp++;
        if (pending !== 4'b0001 || greens !== 4'b0010) begin
            n_err++;
            $display("FAIL rm_before: actual pending=%b greens=%b required pending=0001 greens=0010", pending, greens);
        end
        reset = 1'b1;
        exp_q.delete();
        tick();
        n_cmp++;
        if (pending !== 4'b0000 || greens !== 4'b0000) begin
            n_err++;
            $display("FAIL rm_drop: actual pending=%b greens=%b required 0000/0000", pending, greens);
        end
        tick();
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < CLEAR_CYCLES + 12; i++) begin
            tick();
            if (greens !== 4'b0000 || pending !== 4'b0000) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL rm_after: actual=%0d non-quiet cycles required=0", bad);
        end
        up_req = 1'b1;
        exp_q.push_back(4'b0001);
        tick();
        up_req = 1'b0;
        tick();
        e = exp_q.pop_front();
        n_cmp++;
        if (greens !== e) begin
            n_err++;
            $display("FAIL rm_idle_grant: actual=%b required=%b", greens, e);
        end
    endtask

    // Scenario sequence and final report
    initial begin
        tick();
        test_reset();
        test_single_up();
        test_min_green();
        test_round_robin();
        test_ped_ignore();
        test_reset_mid_green();
        tick(2);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: actual=%0d left required=0", exp_q.size());
        end
        n_cmp++;
        if (inv_viol != 0) begin
            n_err++;
            $display("FAIL invariants: actual=%0d violations required=0", inv_viol);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
